// File: rtl/sll_iter_pkg.sv
// Shared types and widths for the iterative logical-left shifter.
package sll_iter_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : sll_iter_pkg

// File: rtl/sll_iter_if.sv
// Request/response bundle for sll_iter: operands in, busy/done/result out.
interface sll_iter_if;
  import sll_iter_pkg::*;

  logic              start;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;

  modport master (
    output start, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, a, b,
    output busy, done, result
  );

endinterface : sll_iter_if

// File: rtl/sll_iter.sv
// Multi-cycle logical left shifter: one bit position per clock, done pulses
// for one cycle and the result holds until the next accepted request.
module sll_iter
  import sll_iter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  sll_iter_if.slave  bus
);

  state_e               state_q, state_d;
  logic [DATA_W-1:0]    sreg_q, sreg_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;

  // Upper shift-amount bits are architecturally ignored.
  logic unused_b_hi;
  assign unused_b_hi = ^bus.b[DATA_W-1:SHAMT_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sreg_d  = bus.a;
          cnt_d   = bus.b[SHAMT_W-1:0];
          state_d = (bus.b[SHAMT_W-1:0] != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        sreg_d = {sreg_q[DATA_W-2:0], 1'b0};
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs come straight from registers, so no input reaches them combinationally.
  assign bus.busy   = (state_q != IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = sreg_q;

endmodule : sll_iter

// File: doc/sll_iter.md
SLL_ITER -- requirements
Module: sll_iter

Interface
REQ-001 SHALL have no parameters; datapath width fixed at 32, shift-amount width fixed at 5.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request; accepted only when busy=0.
REQ-005 a  input  32  operand to be shifted; sampled on the accept edge only.
REQ-006 b  input  32  shift amount; only b[4:0] used, b[31:5] ignored; sampled on the accept edge only.
REQ-007 busy  output  1  high while an operation is in progress (SHIFT or DONE).
REQ-008 done  output  1  single-cycle pulse; result valid in that cycle.
REQ-009 result  output  32  logical-left-shifted operand; zero-filled from bit 0.

Function
REQ-010 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-011 IDLE with start=1 at edge T: capture sreg<=a, cnt<=b[4:0]; next state SHIFT if b[4:0]!=0, else DONE.
REQ-012 SHIFT, every edge: sreg<=sreg<<1 with bit0<=0, cnt<=cnt-1; next state DONE when cnt==1, else stay in SHIFT.
REQ-013 DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
REQ-014 Latency: with N=b[4:0] and start accepted at edge T, done is high in cycle T+1+N; N=0 gives done at T+1, N=31 gives done at T+32.
REQ-015 result is driven from sreg in every state; in DONE it equals (a << N) truncated to 32 bits.
REQ-016 result SHALL hold its DONE value through IDLE until the next accepted start.
REQ-017 busy = (state != IDLE); start while busy=1, including during DONE, SHALL be ignored, with no effect on sreg or cnt.
REQ-018 start sampled in IDLE in the cycle after done is accepted normally, so back-to-back operations proceed with 1 idle cycle minimum.
REQ-019 Changes to a or b after the accept edge SHALL NOT affect the operation in flight.
REQ-020 Bits shifted out of sreg[31] are discarded; no carry or overflow output.
REQ-021 No combinational path from start, a or b to any output.

Reset
REQ-022 rst_n=0 sampled at a rising edge: state<=IDLE, sreg<=0, cnt<=0; result=0, busy=0, done=0 from the following cycle.
REQ-023 Reset SHALL take priority over start and over any in-flight operation; an aborted operation produces no done pulse.
REQ-024 start asserted in the same cycle as rst_n=0 SHALL be ignored.

Structure
REQ-025 Shared package sll_iter_pkg holds the FSM state enum (IDLE/SHIFT/DONE), DATA_W=32 and SHAMT_W=5.
REQ-026 Single module, no sub-module: FSM, 5-bit down-counter and 32-bit shift register are all inline.

Verification
REQ-027 a=00000001, b=00000001, start at T -> done at T+2, result=00000002.
REQ-028 a=0046F800, b=00000005 -> done at T+6, result=08DF0000; a=00000001, b=0000001F -> done at T+32, result=80000000.
REQ-029 a=DEADBEEF, b=00000000 -> done at T+1, result=DEADBEEF; a=00000004, b=00000022 (only b[4:0]=2 used) -> done at T+3, result=00000010.
REQ-030 Run a=00000003, b=00000004; pulse start with a=FFFFFFFF at T+2 and change a/b mid-operation -> done at T+5, result=00000030, no second done pulse.
REQ-031 Run a=00000001, b=0000000A; rst_n=0 at T+3 -> busy=0, result=00000000 next cycle, no done pulse; a new start then completes normally.
REQ-032 Two back-to-back operations with start held high -> second accepted in the IDLE cycle after done, both results correct, and done is never high on consecutive cycles.
